input_jpg: RTL and testbench

- Receives a raster pixel stream (valid-qualified 24-bit RGB) and writes one full frame into the single-port image RAM (port A).
- Counterpart to the frame read-out block: it fills the same 300x210 buffer that the read-out block later streams out.
- Controlled by the same ena/done handshake used by the pipeline's top-level sequencer.

---
 rtl/input_jpg_pkg.sv | 14 +
 rtl/input_jpg_if.sv | 22 ++
 rtl/input_jpg.sv | 44 ++++
 tb/tb_input_jpg.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/input_jpg_pkg.sv
// input_jpg_pkg: frame geometry, pixel/address widths and the STATUS encodings
// shared by the frame load and frame read-out blocks.
package input_jpg_pkg;
  localparam int IMG_W = 300;
  localparam int IMG_H = 210;
  localparam int FRAME_PIX = IMG_W * IMG_H;
  localparam int DATA_W = 24;
  localparam int ADDR_W = 16;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } status_t;
endpackage

// File: rtl/input_jpg_if.sv
// input_jpg_if: sequencer handshake, incoming pixel stream and RAM port A write bus.
interface input_jpg_if;
  import input_jpg_pkg::*;
  logic ena;
  logic done;
  logic iDVAL;
  logic iSOF;
  logic [DATA_W-1:0] iDATA;
  logic wrenA;
  logic [ADDR_W-1:0] iAddrA;
  logic [DATA_W-1:0] iDataA;
  logic oBUSY;
  logic oERR;
  modport master (
    output ena, iDVAL, iSOF, iDATA,
    input done, wrenA, iAddrA, iDataA, oBUSY, oERR
  );
  modport slave (
    input ena, iDVAL, iSOF, iDATA,
    output done, wrenA, iAddrA, iDataA, oBUSY, oERR
  );
endinterface

// File: rtl/input_jpg.sv
// input_jpg: writes one raster frame of valid-qualified RGB pixels into image RAM port A,
// started by ena and finished with a one-cycle done pulse.
module input_jpg #(
  parameter int IMG_W = 300,
  parameter int IMG_H = 210
) (
  input logic iCLK,
  input logic iRST_N,
  input_jpg_if.slave bus
);
  import input_jpg_pkg::*;
  localparam int FRAME_PIX = IMG_W * IMG_H;
  status_t status;
  logic [ADDR_W-1:0] pixCnt;
  logic start, accept, lastPix, stray;
  assign start = status == IDLE && bus.ena;
  assign accept = status == LOAD && bus.iDVAL;
  // a resync on the final count wins, so the frame keeps going
  assign lastPix = accept && !bus.iSOF && pixCnt == ADDR_W'(FRAME_PIX - 1);
  assign stray = status != LOAD && bus.iDVAL;
  assign bus.oBUSY = status == LOAD;
  assign bus.done = status == DONE;
  always_ff @(posedge iCLK or negedge iRST_N)
    if (!iRST_N) begin
      status <= IDLE;
      pixCnt <= '0;
      bus.wrenA <= 1'b0;
      bus.iAddrA <= '0;
      bus.iDataA <= '0;
      bus.oERR <= 1'b0;
    end else begin
      bus.wrenA <= accept;
      if (accept) begin
        bus.iAddrA <= bus.iSOF ? '0 : pixCnt;
        bus.iDataA <= bus.iDATA;
        pixCnt <= bus.iSOF ? ADDR_W'(1) : lastPix ? '0 : pixCnt + 1'b1;
      end
      if (start) begin
        pixCnt <= '0;
        bus.oERR <= 1'b0;
      end else if (stray) bus.oERR <= 1'b1;
      status <= start ? LOAD : lastPix ? DONE : status == LOAD ? LOAD : IDLE;
    end
endmodule

// File: tb/tb_input_jpg.sv
// tb_input_jpg: directed and random pixel streams against an integer frame-loader model,
// using a reduced frame so every scenario completes whole frames quickly.
module tb_input_jpg;
  localparam int W = 30;
  localparam int H = 21;
  localparam int FRAME = W * H;
  logic iCLK = 0;
  logic rstN = 0;
  input_jpg_if bus();
  input_jpg #(.IMG_W(W), .IMG_H(H)) dut (.iCLK(iCLK), .iRST_N(rstN), .bus(bus.slave));
  always #5 iCLK = ~iCLK;
  int errors = 0;
  int checks = 0;
  int wrCnt = 0;
  int doneCnt = 0;
  int doneAddr = -1;
  logic doneWr = 0;
  int mSt = 0;
  int mNext = 0;
  int mIdx = 0;
  int mAddr = 0;
  logic [23:0] mData = 0;
  logic mWr = 0;
  logic mErr = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 20) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step();
    @(negedge iCLK);
    #1;
  endtask
  task automatic waitDone(input int lim);
    int n = 0;
    while (bus.done !== 1'b1 && n < lim) begin
      step();
      n++;
    end
    chk("done_timeout", {31'd0, bus.done}, 1);
  endtask
  // model: 0 idle, 1 loading, 2 frame complete; pixels land at the next linear index
  always @(posedge iCLK or negedge rstN) begin
    if (!rstN) begin
      mSt = 0; mIdx = 0; mWr = 0; mAddr = 0; mData = 0; mErr = 0;
    end else begin
      mNext = mSt;
      mWr = 0;
      if (mSt == 1) begin
        if (bus.iDVAL) begin
          mWr = 1;
          mData = bus.iDATA;
          if (bus.iSOF) begin
            mAddr = 0;
            mIdx = 1;
          end else begin
            mAddr = mIdx;
            mIdx = mIdx + 1;
            if (mIdx == FRAME) begin
              mIdx = 0;
              mNext = 2;
            end
          end
        end
      end else begin
        if (bus.iDVAL) mErr = 1;
        if (mSt == 0 && bus.ena) begin
          mNext = 1;
          mIdx = 0;
          mErr = 0;
        end else mNext = 0;
      end
      mSt = mNext;
    end
  end
  always @(negedge iCLK) if (rstN) begin
    chk("wrenA", {31'd0, bus.wrenA}, {31'd0, mWr});
    chk("done", {31'd0, bus.done}, {31'd0, mSt == 2});
    chk("oBUSY", {31'd0, bus.oBUSY}, {31'd0, mSt == 1});
    chk("oERR", {31'd0, bus.oERR}, {31'd0, mErr});
    chk("iAddrA", {16'd0, bus.iAddrA}, mAddr);
    chk("iDataA", {8'd0, bus.iDataA}, {8'd0, mData});
    if (bus.wrenA) wrCnt++;
    if (bus.done) begin
      doneCnt++;
      doneAddr = bus.iAddrA;
      doneWr = bus.wrenA;
    end
  end
  initial begin
    bus.ena = 0; bus.iDVAL = 0; bus.iSOF = 0; bus.iDATA = 0;
    step();
    step();
    chk("rst_wrenA", {31'd0, bus.wrenA}, 0);
    chk("rst_done", {31'd0, bus.done}, 0);
    chk("rst_busy", {31'd0, bus.oBUSY}, 0);
    chk("rst_err", {31'd0, bus.oERR}, 0);
    chk("rst_addr", {16'd0, bus.iAddrA}, 0);
    chk("rst_data", {8'd0, bus.iDataA}, 0);
    rstN = 1;
    step();
    // back-to-back frame, data = index
    bus.ena = 1;
    step();
    bus.ena = 0;
    wrCnt = 0; doneCnt = 0;
    for (int k = 0; k < FRAME; k++) begin
      bus.iDVAL = 1; bus.iDATA = 24'(k);
      step();
    end
    bus.iDVAL = 0;
    step(); step(); step();
    chk("f1_writes", wrCnt, FRAME);
    chk("f1_done_cnt", doneCnt, 1);
    chk("f1_done_addr", doneAddr, FRAME - 1);
    chk("f1_done_wr", {31'd0, doneWr}, 1);
    chk("f1_idle_busy", {31'd0, bus.oBUSY}, 0);
    // alternating valid
    bus.ena = 1;
    step();
    bus.ena = 0;
    wrCnt = 0; doneCnt = 0;
    for (int k = 0; k < FRAME; k++) begin
      bus.iDVAL = 1; bus.iDATA = 24'($urandom);
      step();
      bus.iDVAL = 0;
      step();
    end
    step();
    chk("alt_writes", wrCnt, FRAME);
    chk("alt_done_cnt", doneCnt, 1);
    // stray pixel in IDLE
    bus.iDVAL = 1; bus.iDATA = 24'hABCDEF;
    step();
    bus.iDVAL = 0;
    chk("err_set", {31'd0, bus.oERR}, 1);
    chk("err_nowrite", {31'd0, bus.wrenA}, 0);
    bus.ena = 1;
    step();
    bus.ena = 0;
    chk("err_clear", {31'd0, bus.oERR}, 0);
    chk("err_busy", {31'd0, bus.oBUSY}, 1);
    // resync after 100 pixels
    for (int k = 0; k < 100; k++) begin
      bus.iDVAL = 1; bus.iDATA = 24'($urandom);
      step();
    end
    doneCnt = 0;
    bus.iSOF = 1; bus.iDATA = 24'h123456;
    step();
    bus.iSOF = 0;
    chk("sof_wr", {31'd0, bus.wrenA}, 1);
    chk("sof_addr", {16'd0, bus.iAddrA}, 0);
    chk("sof_data", {8'd0, bus.iDataA}, 32'h123456);
    bus.iDATA = 24'h000777;
    step();
    chk("sof_next_addr", {16'd0, bus.iAddrA}, 1);
    for (int k = 0; k < FRAME - 2; k++) begin
      if (k == FRAME - 3) chk("sof_no_early_done", doneCnt, 0);
      bus.iDATA = 24'($urandom);
      step();
    end
    bus.iDVAL = 0;
    chk("sof_done_cnt", doneCnt, 1);
    chk("sof_done_addr", doneAddr, FRAME - 1);
    step(); step();
    // asynchronous reset mid-frame
    bus.ena = 1;
    step();
    bus.ena = 0;
    for (int k = 0; k < 50; k++) begin
      bus.iDVAL = 1; bus.iDATA = 24'hFFFF00 | 24'(k);
      step();
    end
    chk("pre_rst_addr", {16'd0, bus.iAddrA}, 49);
    #2 rstN = 0;
    #1;
    chk("arst_wrenA", {31'd0, bus.wrenA}, 0);
    chk("arst_addr", {16'd0, bus.iAddrA}, 0);
    chk("arst_data", {8'd0, bus.iDataA}, 0);
    chk("arst_busy", {31'd0, bus.oBUSY}, 0);
    bus.iDVAL = 0;
    step();
    rstN = 1;
    step();
    chk("arst_idle", {31'd0, bus.oBUSY}, 0);
    bus.ena = 1;
    step();
    bus.ena = 0;
    bus.iDVAL = 1; bus.iDATA = 24'h000077;
    step();
    bus.iDVAL = 0;
    chk("arst_restart_addr", {16'd0, bus.iAddrA}, 0);
    chk("arst_restart_data", {8'd0, bus.iDataA}, 32'h77);
    rstN = 0;
    step();
    rstN = 1;
    step();
    // ena held high across two frames
    bus.ena = 1; bus.iDVAL = 1;
    doneCnt = 0;
    for (int k = 0; k < FRAME + 5 && bus.done !== 1'b1; k++) begin
      bus.iDATA = 24'($urandom);
      step();
    end
    chk("rearm_done1", {31'd0, bus.done}, 1);
    step();
    chk("rearm_idle", {31'd0, bus.oBUSY}, 0);
    step();
    chk("rearm_load", {31'd0, bus.oBUSY}, 1);
    step();
    chk("rearm_addr0", {16'd0, bus.iAddrA}, 0);
    waitDone(FRAME + 5);
    bus.ena = 0; bus.iDVAL = 0;
    chk("rearm_done_cnt", doneCnt, 2);
    step(); step();
    // random traffic
    for (int k = 0; k < 6000; k++) begin
      bus.ena = ($urandom % 16) == 0;
      bus.iDVAL = ($urandom % 8) != 0;
      bus.iSOF = ($urandom % 300) == 0;
      bus.iDATA = 24'($urandom);
      step();
    end
    bus.ena = 0; bus.iDVAL = 0; bus.iSOF = 0;
    step(); step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
